// File: rtl/mcu_timer_multi.sv
// Multi-channel interval timer: prescaler + down-counter per channel, one-shot/periodic.
// Optional MCU_TIMER_CASCADE_EN adds a cascade input chaining channel i to i-1 expiry.
module mcu_timer_multi #(
    parameter int NCH   = 2,
    parameter int CNT_W = 6,
    parameter int PRE_W = 6,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 ld_valid,
    input  logic [CHW-1:0]       ld_ch,
    input  logic [CNT_W-1:0]     ld_val,
    input  logic                 ld_mode,
    input  logic [NCH-1:0]       irq_ack,
`ifdef MCU_TIMER_CASCADE_EN
    input  logic [NCH-1:0]       cascade,
`endif
    output logic [NCH-1:0]       tm,
    output logic [NCH-1:0]       irq,
    output logic [NCH*CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] count  [NCH];
    logic [CNT_W-1:0] reload [NCH];
    logic [PRE_W-1:0] pre    [NCH];
    logic [NCH-1:0]   mode;
    logic [NCH-1:0]   ld_hit;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   expire;

    // Channels are evaluated in order so a cascade chain settles in one pass.
    always_comb begin
        ld_hit = '0;
        tick   = '0;
        expire = '0;
        for (int i = 0; i < NCH; i++) begin
            ld_hit[i] = ld_valid && (ld_ch == CHW'(i));
`ifdef MCU_TIMER_CASCADE_EN
            if (i > 0 && cascade[i])
                tick[i] = !tm[i] && expire[i-1];
            else
                tick[i] = !tm[i] && clk_en;
`else
            tick[i] = !tm[i] && clk_en;
`endif
            expire[i] = tick[i] && !ld_hit[i] && (count[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tm   <= '1;
            irq  <= '0;
            mode <= '0;
            for (int i = 0; i < NCH; i++) begin
                count[i]  <= '0;
                reload[i] <= '0;
                pre[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ld_hit[i]) begin
                    count[i]  <= ld_val;
                    reload[i] <= ld_val;
                    mode[i]   <= ld_mode;
                    pre[i]    <= '0;
                    tm[i]     <= 1'b0;
                end else if (expire[i]) begin
                    if (mode[i]) begin
                        count[i] <= reload[i];
                        pre[i]   <= '0;
                    end else begin
                        tm[i] <= 1'b1;
                    end
                end else if (tick[i]) begin
                    pre[i] <= pre[i] + 1'b1;
                    if (&pre[i])
                        count[i] <= count[i] - 1'b1;
                end

                // A coincident expiry beats the acknowledge.
                if (expire[i])
                    irq[i] <= 1'b1;
                else if (irq_ack[i])
                    irq[i] <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign cnt[g*CNT_W +: CNT_W] = count[g];
    end

endmodule

// File: tb/tb_mcu_timer_multi.sv
// Directed scoreboard bench for mcu_timer_multi (NCH=2, CNT_W=4, PRE_W=2).
module tb_mcu_timer_multi;

    localparam int NCH   = 2;
    localparam int CNT_W = 4;
    localparam int PRE_W = 2;
    localparam int CHW   = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_en;
    logic               ld_valid;
    logic [CHW-1:0]     ld_ch;
    logic [CNT_W-1:0]   ld_val;
    logic               ld_mode;
    logic [NCH-1:0]     irq_ack;
    logic [NCH-1:0]     cascade;
    logic [NCH-1:0]     tm;
    logic [NCH-1:0]     irq;
    logic [NCH*CNT_W-1:0] cnt;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    mcu_timer_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W), .CHW(CHW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .ld_valid(ld_valid),
        .ld_ch(ld_ch),
        .ld_val(ld_val),
        .ld_mode(ld_mode),
        .irq_ack(irq_ack),
`ifdef MCU_TIMER_CASCADE_EN
        .cascade(cascade),
`endif
        .tm(tm),
        .irq(irq),
        .cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // sel: 0=tm, 1=irq, 2=cnt ch0, 3=cnt ch1
    task automatic drain();
        exp_t e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = {6'b0, tm};
                1:       obs = {6'b0, irq};
                2:       obs = {4'b0, cnt[3:0]};
                default: obs = {4'b0, cnt[7:4]};
            endcase
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic load(input logic ch, input logic [3:0] v, input logic m);
        ld_valid = 1'b1;
        ld_ch    = ch;
        ld_val   = v;
        ld_mode  = m;
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; ld_valid = 1'b0; ld_ch = '0;
        ld_val = '0; ld_mode = 1'b0; irq_ack = '0; cascade = '0;
        step(2);
        reset = 1'b0;
        push("rst_tm", 0, 8'h3); push("rst_irq", 1, 8'h0);
        push("rst_c0", 2, 8'h0); push("rst_c1", 3, 8'h0);
        drain();

        // one-shot ch0, val 3
        load(1'b0, 4'd3, 1'b0);
        step(1); ld_valid = 1'b0;
        push("os_ld_tm", 0, 8'h2); push("os_ld_c0", 2, 8'h3); drain();
        step(4); push("os_t4", 2, 8'h2); drain();
        step(4); push("os_t8", 2, 8'h1); drain();
        step(4); push("os_t12", 2, 8'h0); push("os_t12_tm", 0, 8'h2);
        push("os_t12_irq", 1, 8'h0); drain();
        step(1); push("os_t13_tm", 0, 8'h3); push("os_t13_irq", 1, 8'h1); drain();
        step(3); push("os_hold", 2, 8'h0); push("os_hold_tm", 0, 8'h3); drain();

        // zero load ch1 and ack
        load(1'b1, 4'd0, 1'b0);
        step(1); ld_valid = 1'b0;
        push("z_ld_tm", 0, 8'h1); drain();
        step(1); push("z_tm", 0, 8'h3); push("z_irq", 1, 8'h3); drain();
        irq_ack = 2'b10;
        step(1); irq_ack = 2'b00;
        push("ack1_irq", 1, 8'h1); push("ack1_c0", 2, 8'h0);
        push("ack1_tm", 0, 8'h3); drain();
        irq_ack = 2'b01;
        step(1); irq_ack = 2'b00;
        push("ack0_irq", 1, 8'h0); drain();

        // periodic ch0, val 1: period 5
        load(1'b0, 4'd1, 1'b1);
        step(1); ld_valid = 1'b0;
        push("p_ld_tm", 0, 8'h2); drain();
        step(4); push("p_t4_irq", 1, 8'h0); push("p_t4_c0", 2, 8'h0); drain();
        step(1); push("p_t5_irq", 1, 8'h1); push("p_t5_tm", 0, 8'h2);
        push("p_t5_c0", 2, 8'h1); drain();
        irq_ack = 2'b01;
        step(1); irq_ack = 2'b00;
        push("p_ack", 1, 8'h0); drain();
        step(3); push("p2_t4_irq", 1, 8'h0); drain();
        step(1); push("p2_irq", 1, 8'h1); push("p2_tm", 0, 8'h2); drain();

        // ack coinciding with expiry: set wins
        irq_ack = 2'b01;
        step(1); irq_ack = 2'b00;
        push("c_ack", 1, 8'h0); drain();
        step(3);
        irq_ack = 2'b01;
        step(1); irq_ack = 2'b00;
        push("c_setwins", 1, 8'h1); drain();

        // reload on the expiry cycle: no irq, next expiry 9 ticks on
        irq_ack = 2'b01;
        step(1); irq_ack = 2'b00;
        push("r_ack", 1, 8'h0); drain();
        step(3);
        load(1'b0, 4'd2, 1'b1);
        step(1); ld_valid = 1'b0;
        push("r_noirq", 1, 8'h0); push("r_c0", 2, 8'h2); push("r_tm", 0, 8'h2); drain();
        step(8); push("r_t8_irq", 1, 8'h0); push("r_t8_c0", 2, 8'h0); drain();
        step(1); push("r_t9_irq", 1, 8'h1); push("r_t9_c0", 2, 8'h2); drain();

        // gated enable: one-shot val 1, ticks on every other cycle
        irq_ack = 2'b01;
        load(1'b0, 4'd1, 1'b0);
        step(1); ld_valid = 1'b0; irq_ack = 2'b00;
        push("g_ld_irq", 1, 8'h0); push("g_ld_tm", 0, 8'h2); drain();
        for (int k = 0; k < 9; k++) begin
            clk_en = k[0];
            step(1);
        end
        push("g_c9_tm", 0, 8'h2); push("g_c9_irq", 1, 8'h0); drain();
        clk_en = 1'b1;
        step(1);
        push("g_c10_tm", 0, 8'h3); push("g_c10_irq", 1, 8'h1); drain();

        // reset mid-count with a colliding load
        load(1'b1, 4'd5, 1'b1);
        step(1); ld_valid = 1'b0;
        step(2);
        push("m_tm", 0, 8'h1); drain();
        reset = 1'b1;
        load(1'b0, 4'd7, 1'b1);
        step(1); reset = 1'b0; ld_valid = 1'b0;
        push("m_rst_tm", 0, 8'h3); push("m_rst_irq", 1, 8'h0);
        push("m_rst_c0", 2, 8'h0); push("m_rst_c1", 3, 8'h0); drain();

`ifdef MCU_TIMER_CASCADE_EN
        // ch1 advances once per ch0 expiry
        cascade = 2'b10;
        load(1'b1, 4'd1, 1'b0);
        step(1);
        load(1'b0, 4'd0, 1'b1);
        step(1); ld_valid = 1'b0;
        push("cas_ld_tm", 0, 8'h0); push("cas_ld_c1", 3, 8'h1); drain();
        step(4); push("cas_e4_tm", 0, 8'h0); push("cas_e4_c1", 3, 8'h0); drain();
        step(1); push("cas_e5_tm", 0, 8'h2); push("cas_e5_irq", 1, 8'h3); drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
